csr_axil_arbiter: RTL and testbench

- Two-master to one-slave AXI4-lite arbiter in front of the bster CSR slave.
- Lets two control agents (e.g. host bridge and debug/test master) share one CSR register interface.
- Write and read channels are arbitrated independently.
- Each channel carries at most one outstanding transaction.

---
 rtl/bster_h.sv | 22 ++
 rtl/rr_arb2.sv | 54 +++++
 rtl/csr_axil_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_csr_axil_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bster_h.sv
// Shared types and constants for the bster CSR AXI4-lite arbiter.
// Holds the per-channel FSM encodings and the AXI response codes.
package bster_h;

  localparam int NB_CSR_MASTERS = 2;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE      = 2'd0,
    WR_ADDR_DATA = 2'd1,
    WR_RESP      = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester arbiter: grant registered on the arbitration cycle, held until done_i.
// CSR_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins); default is round-robin.
module rr_arb2
  import bster_h::*;
(
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [NB_CSR_MASTERS-1:0] req_i,
  input  logic                      arb_en_i,
  input  logic                      done_i,
  output logic [NB_CSR_MASTERS-1:0] gnt_o
);

  logic [NB_CSR_MASTERS-1:0] gnt_q, gnt_d, pick;

`ifdef CSR_ARB_FIXED_PRIO_EN
  always_comb begin
    pick = req_i;
    if (req_i[0]) pick = 2'b01;
  end
`else
  // ptr_q names the port preferred on a tie; it moves to the other port after each done.
  logic ptr_q, ptr_d;

  always_comb begin
    pick = req_i;
    if (req_i == 2'b11) pick = ptr_q ? 2'b10 : 2'b01;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (done_i) ptr_d = ~gnt_q[1];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ptr_q <= 1'b0;
    else          ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    gnt_d = gnt_q;
    if (done_i)                   gnt_d = '0;
    else if (arb_en_i && |req_i)  gnt_d = pick;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) gnt_q <= '0;
    else          gnt_q <= gnt_d;
  end

  assign gnt_o = gnt_q;

endmodule

// File: rtl/csr_axil_arbiter.sv
// Two-master to one-slave AXI4-lite CSR arbiter; write and read channels arbitrate independently,
// one outstanding transaction each. CSR_ARB_FIXED_PRIO_EN switches ties to fixed priority.
module csr_axil_arbiter
  import bster_h::*;
#(
  parameter int CSR_ADDR_WIDTH = 8,
  parameter int CSR_DATA_WIDTH = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        s0_awvalid,
  input  logic [CSR_ADDR_WIDTH-1:0]   s0_awaddr,
  input  logic [1:0]                  s0_awprot,
  output logic                        s0_awready,
  input  logic                        s0_wvalid,
  input  logic [CSR_DATA_WIDTH-1:0]   s0_wdata,
  input  logic [CSR_DATA_WIDTH/8-1:0] s0_wstrb,
  output logic                        s0_wready,
  output logic                        s0_bvalid,
  output logic [1:0]                  s0_bresp,
  input  logic                        s0_bready,
  input  logic                        s0_arvalid,
  input  logic [CSR_ADDR_WIDTH-1:0]   s0_araddr,
  input  logic [1:0]                  s0_arprot,
  output logic                        s0_arready,
  output logic                        s0_rvalid,
  output logic [CSR_DATA_WIDTH-1:0]   s0_rdata,
  output logic [1:0]                  s0_rresp,
  input  logic                        s0_rready,
  input  logic                        s1_awvalid,
  input  logic [CSR_ADDR_WIDTH-1:0]   s1_awaddr,
  input  logic [1:0]                  s1_awprot,
  output logic                        s1_awready,
  input  logic                        s1_wvalid,
  input  logic [CSR_DATA_WIDTH-1:0]   s1_wdata,
  input  logic [CSR_DATA_WIDTH/8-1:0] s1_wstrb,
  output logic                        s1_wready,
  output logic                        s1_bvalid,
  output logic [1:0]                  s1_bresp,
  input  logic                        s1_bready,
  input  logic                        s1_arvalid,
  input  logic [CSR_ADDR_WIDTH-1:0]   s1_araddr,
  input  logic [1:0]                  s1_arprot,
  output logic                        s1_arready,
  output logic                        s1_rvalid,
  output logic [CSR_DATA_WIDTH-1:0]   s1_rdata,
  output logic [1:0]                  s1_rresp,
  input  logic                        s1_rready,
  output logic                        m_awvalid,
  output logic [CSR_ADDR_WIDTH-1:0]   m_awaddr,
  output logic [1:0]                  m_awprot,
  input  logic                        m_awready,
  output logic                        m_wvalid,
  output logic [CSR_DATA_WIDTH-1:0]   m_wdata,
  output logic [CSR_DATA_WIDTH/8-1:0] m_wstrb,
  input  logic                        m_wready,
  input  logic                        m_bvalid,
  input  logic [1:0]                  m_bresp,
  output logic                        m_bready,
  output logic                        m_arvalid,
  output logic [CSR_ADDR_WIDTH-1:0]   m_araddr,
  output logic [1:0]                  m_arprot,
  input  logic                        m_arready,
  input  logic                        m_rvalid,
  input  logic [CSR_DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]                  m_rresp,
  output logic                        m_rready
);

  logic [NB_CSR_MASTERS-1:0] wgnt, rgnt;
  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic wr_done, rd_done;

  rr_arb2 u_wr_arb (
    .clk_i    (aclk),
    .rst_n_i  (aresetn),
    .req_i    ({s1_awvalid, s0_awvalid}),
    .arb_en_i (wr_state_q == WR_IDLE),
    .done_i   (wr_done),
    .gnt_o    (wgnt)
  );

  rr_arb2 u_rd_arb (
    .clk_i    (aclk),
    .rst_n_i  (aresetn),
    .req_i    ({s1_arvalid, s0_arvalid}),
    .arb_en_i (rd_state_q == RD_IDLE),
    .done_i   (rd_done),
    .gnt_o    (rgnt)
  );

  // Granted-port views; only meaningful while the matching FSM is past IDLE.
  logic                        g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;
  logic [CSR_ADDR_WIDTH-1:0]   g_awaddr, g_araddr;
  logic [1:0]                  g_awprot, g_arprot;
  logic [CSR_DATA_WIDTH-1:0]   g_wdata;
  logic [CSR_DATA_WIDTH/8-1:0] g_wstrb;

  assign g_awvalid = wgnt[1] ? s1_awvalid : s0_awvalid;
  assign g_awaddr  = wgnt[1] ? s1_awaddr  : s0_awaddr;
  assign g_awprot  = wgnt[1] ? s1_awprot  : s0_awprot;
  assign g_wvalid  = wgnt[1] ? s1_wvalid  : s0_wvalid;
  assign g_wdata   = wgnt[1] ? s1_wdata   : s0_wdata;
  assign g_wstrb   = wgnt[1] ? s1_wstrb   : s0_wstrb;
  assign g_bready  = wgnt[1] ? s1_bready  : s0_bready;
  assign g_arvalid = rgnt[1] ? s1_arvalid : s0_arvalid;
  assign g_araddr  = rgnt[1] ? s1_araddr  : s0_araddr;
  assign g_arprot  = rgnt[1] ? s1_arprot  : s0_arprot;
  assign g_rready  = rgnt[1] ? s1_rready  : s0_rready;

  logic                      awready_g, wready_g, bvalid_g, arready_g, rvalid_g;
  logic [1:0]                bresp_g, rresp_g;
  logic [CSR_DATA_WIDTH-1:0] rdata_g;

  always_comb begin
    wr_state_d = wr_state_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    wr_done    = 1'b0;
    m_awvalid  = 1'b0;
    m_awaddr   = '0;
    m_awprot   = '0;
    m_wvalid   = 1'b0;
    m_wdata    = '0;
    m_wstrb    = '0;
    m_bready   = 1'b0;
    awready_g  = 1'b0;
    wready_g   = 1'b0;
    bvalid_g   = 1'b0;
    bresp_g    = '0;
    case (wr_state_q)
      WR_IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (s0_awvalid || s1_awvalid) wr_state_d = WR_ADDR_DATA;
      end
      WR_ADDR_DATA: begin
        if (!aw_done_q) begin
          m_awvalid = g_awvalid;
          m_awaddr  = g_awaddr;
          m_awprot  = g_awprot;
          awready_g = m_awready;
        end
        if (!w_done_q) begin
          m_wvalid = g_wvalid;
          m_wdata  = g_wdata;
          m_wstrb  = g_wstrb;
          wready_g = m_wready;
        end
        aw_done_d = aw_done_q | (m_awvalid & m_awready);
        w_done_d  = w_done_q  | (m_wvalid & m_wready);
        if (aw_done_d && w_done_d) wr_state_d = WR_RESP;
      end
      WR_RESP: begin
        m_bready = g_bready;
        bvalid_g = m_bvalid;
        bresp_g  = m_bresp;
        if (m_bvalid && g_bready) begin
          wr_state_d = WR_IDLE;
          wr_done    = 1'b1;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_done    = 1'b0;
    m_arvalid  = 1'b0;
    m_araddr   = '0;
    m_arprot   = '0;
    m_rready   = 1'b0;
    arready_g  = 1'b0;
    rvalid_g   = 1'b0;
    rdata_g    = '0;
    rresp_g    = '0;
    case (rd_state_q)
      RD_IDLE: begin
        if (s0_arvalid || s1_arvalid) rd_state_d = RD_ADDR;
      end
      RD_ADDR: begin
        m_arvalid = g_arvalid;
        m_araddr  = g_araddr;
        m_arprot  = g_arprot;
        arready_g = m_arready;
        if (g_arvalid && m_arready) rd_state_d = RD_DATA;
      end
      RD_DATA: begin
        m_rready = g_rready;
        rvalid_g = m_rvalid;
        rdata_g  = m_rdata;
        rresp_g  = m_rresp;
        if (m_rvalid && g_rready) begin
          rd_state_d = RD_IDLE;
          rd_done    = 1'b1;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  // Return paths reach only the granted port; the other stays all-zero.
  assign s0_awready = wgnt[0] & awready_g;
  assign s1_awready = wgnt[1] & awready_g;
  assign s0_wready  = wgnt[0] & wready_g;
  assign s1_wready  = wgnt[1] & wready_g;
  assign s0_bvalid  = wgnt[0] & bvalid_g;
  assign s1_bvalid  = wgnt[1] & bvalid_g;
  assign s0_bresp   = wgnt[0] ? bresp_g : '0;
  assign s1_bresp   = wgnt[1] ? bresp_g : '0;
  assign s0_arready = rgnt[0] & arready_g;
  assign s1_arready = rgnt[1] & arready_g;
  assign s0_rvalid  = rgnt[0] & rvalid_g;
  assign s1_rvalid  = rgnt[1] & rvalid_g;
  assign s0_rdata   = rgnt[0] ? rdata_g : '0;
  assign s1_rdata   = rgnt[1] ? rdata_g : '0;
  assign s0_rresp   = rgnt[0] ? rresp_g : '0;
  assign s1_rresp   = rgnt[1] ? rresp_g : '0;

endmodule

// File: tb/tb_csr_axil_arbiter.sv
// Directed bench for csr_axil_arbiter: two master drivers, a simple CSR slave model.
module tb_csr_axil_arbiter;
  import bster_h::*;

  localparam int AW = 8;
  localparam int DW = 32;

  logic aclk = 1'b0;
  logic aresetn;

  logic          s_awvalid [2];
  logic [AW-1:0] s_awaddr  [2];
  logic [1:0]    s_awprot  [2];
  logic          s_awready [2];
  logic          s_wvalid  [2];
  logic [DW-1:0] s_wdata   [2];
  logic [3:0]    s_wstrb   [2];
  logic          s_wready  [2];
  logic          s_bvalid  [2];
  logic [1:0]    s_bresp   [2];
  logic          s_bready  [2];
  logic          s_arvalid [2];
  logic [AW-1:0] s_araddr  [2];
  logic [1:0]    s_arprot  [2];
  logic          s_arready [2];
  logic          s_rvalid  [2];
  logic [DW-1:0] s_rdata   [2];
  logic [1:0]    s_rresp   [2];
  logic          s_rready  [2];

  logic          m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic          m_arvalid, m_arready, m_rvalid, m_rready;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [1:0]    m_awprot, m_arprot, m_bresp, m_rresp;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [3:0]    m_wstrb;

  int vectors = 0;
  int miscompares = 0;
  int cyc_cnt = 0;

  csr_axil_arbiter #(.CSR_ADDR_WIDTH(AW), .CSR_DATA_WIDTH(DW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_awvalid(s_awvalid[0]), .s0_awaddr(s_awaddr[0]), .s0_awprot(s_awprot[0]), .s0_awready(s_awready[0]),
    .s0_wvalid(s_wvalid[0]), .s0_wdata(s_wdata[0]), .s0_wstrb(s_wstrb[0]), .s0_wready(s_wready[0]),
    .s0_bvalid(s_bvalid[0]), .s0_bresp(s_bresp[0]), .s0_bready(s_bready[0]),
    .s0_arvalid(s_arvalid[0]), .s0_araddr(s_araddr[0]), .s0_arprot(s_arprot[0]), .s0_arready(s_arready[0]),
    .s0_rvalid(s_rvalid[0]), .s0_rdata(s_rdata[0]), .s0_rresp(s_rresp[0]), .s0_rready(s_rready[0]),
    .s1_awvalid(s_awvalid[1]), .s1_awaddr(s_awaddr[1]), .s1_awprot(s_awprot[1]), .s1_awready(s_awready[1]),
    .s1_wvalid(s_wvalid[1]), .s1_wdata(s_wdata[1]), .s1_wstrb(s_wstrb[1]), .s1_wready(s_wready[1]),
    .s1_bvalid(s_bvalid[1]), .s1_bresp(s_bresp[1]), .s1_bready(s_bready[1]),
    .s1_arvalid(s_arvalid[1]), .s1_araddr(s_araddr[1]), .s1_arprot(s_arprot[1]), .s1_arready(s_arready[1]),
    .s1_rvalid(s_rvalid[1]), .s1_rdata(s_rdata[1]), .s1_rresp(s_rresp[1]), .s1_rready(s_rready[1]),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready)
  );

  initial forever #5 aclk = ~aclk;
  always @(posedge aclk) cyc_cnt <= cyc_cnt + 1;

  // CSR slave model: samples handshakes at negedge, updates its outputs just after posedge.
  int            b_delay = 2;
  logic [1:0]    bresp_val = AXI_OKAY;
  logic [DW-1:0] rdata_val = '0;
  int            aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0;
  int            wr_act [2] = '{0, 0};
  int            rd_act [2] = '{0, 0};
  logic [AW-1:0] last_awaddr = '0, last_araddr = '0;
  logic [DW-1:0] last_wdata = '0;
  logic [3:0]    last_wstrb = '0;
  bit            sl_aw_h, sl_w_h, sl_b_h, sl_ar_h, sl_r_h, aw_pend, w_pend;
  int            b_wait;

  initial begin
    m_bvalid = 0; m_bresp = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
    aw_pend = 0; w_pend = 0; b_wait = 0;
    forever begin
      @(negedge aclk);
      sl_aw_h = m_awvalid && m_awready;
      sl_w_h  = m_wvalid && m_wready;
      sl_b_h  = m_bvalid && m_bready;
      sl_ar_h = m_arvalid && m_arready;
      sl_r_h  = m_rvalid && m_rready;
      if (sl_aw_h) begin aw_cnt++; last_awaddr = m_awaddr; end
      if (sl_w_h)  begin w_cnt++; last_wdata = m_wdata; last_wstrb = m_wstrb; end
      if (sl_b_h)  b_cnt++;
      if (sl_ar_h) begin ar_cnt++; last_araddr = m_araddr; end
      for (int p = 0; p < 2; p++) begin
        if (s_awready[p] || s_wready[p] || s_bvalid[p] || s_bresp[p] != 0) wr_act[p]++;
        if (s_arready[p] || s_rvalid[p] || s_rdata[p] != 0 || s_rresp[p] != 0) rd_act[p]++;
      end
      @(posedge aclk); #1;
      if (!aresetn) begin
        m_bvalid = 0; m_rvalid = 0; m_rdata = 0; aw_pend = 0; w_pend = 0; b_wait = 0;
        continue;
      end
      if (sl_b_h) m_bvalid = 0;
      if (sl_aw_h) aw_pend = 1;
      if (sl_w_h)  w_pend = 1;
      if (aw_pend && w_pend && !m_bvalid) begin
        if (b_wait >= b_delay) begin
          m_bvalid = 1; m_bresp = bresp_val; aw_pend = 0; w_pend = 0; b_wait = 0;
        end else b_wait++;
      end
      if (sl_r_h) begin m_rvalid = 0; m_rdata = 0; end
      if (sl_ar_h) begin m_rvalid = 1; m_rdata = rdata_val; end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  // Master write driver; aw_lat is the cycle index (0 = cycle awvalid rose) of the AW handshake.
  task automatic mwrite(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [3:0] st, input int w_lead, input int b_hold,
                        output bit ok, output logic [1:0] resp, output int aw_lat, output int t_end);
    bit aw_d, w_d, aw_h, w_h, got;
    int n, held;
    ok = 0; resp = 2'b11; aw_lat = -1; t_end = 0;
    s_awaddr[p] = a; s_wdata[p] = d; s_wstrb[p] = st;
    if (w_lead > 0) begin s_wvalid[p] = 1; cyc(w_lead); end
    s_awvalid[p] = 1; s_wvalid[p] = 1;
    aw_d = 0; w_d = 0; n = 0;
    while (!(aw_d && w_d) && n < 60) begin
      @(negedge aclk);
      aw_h = s_awvalid[p] && s_awready[p];
      w_h  = s_wvalid[p] && s_wready[p];
      @(posedge aclk); #1;
      if (aw_h) begin s_awvalid[p] = 0; aw_d = 1; aw_lat = n; end
      if (w_h)  begin s_wvalid[p] = 0; w_d = 1; end
      n++;
    end
    s_awvalid[p] = 0; s_wvalid[p] = 0;
    if (!(aw_d && w_d)) return;
    s_bready[p] = (b_hold == 0); held = 0; got = 0; n = 0;
    while (!got && n < 60) begin
      @(negedge aclk);
      if (s_bvalid[p] && s_bready[p]) begin got = 1; resp = s_bresp[p]; end
      else if (s_bvalid[p]) held++;
      @(posedge aclk); #1;
      n++;
      if (held >= b_hold) s_bready[p] = 1;
    end
    s_bready[p] = 0;
    ok = got; t_end = cyc_cnt;
  endtask

  task automatic mread(input int p, input logic [AW-1:0] a, output bit ok,
                       output logic [DW-1:0] d, output int t_end);
    bit ar_d, got;
    int n;
    ok = 0; d = '0; t_end = 0;
    s_araddr[p] = a; s_arvalid[p] = 1; ar_d = 0; n = 0;
    while (!ar_d && n < 60) begin
      @(negedge aclk);
      ar_d = s_arvalid[p] && s_arready[p];
      @(posedge aclk); #1;
      n++;
    end
    s_arvalid[p] = 0;
    if (!ar_d) return;
    s_rready[p] = 1; got = 0; n = 0;
    while (!got && n < 60) begin
      @(negedge aclk);
      if (s_rvalid[p] && s_rready[p]) begin got = 1; d = s_rdata[p]; end
      @(posedge aclk); #1;
      n++;
    end
    s_rready[p] = 0;
    ok = got; t_end = cyc_cnt;
  endtask

  task automatic test_reset;
    logic [15:0] ctl;
    logic [63:0] dat;
    aresetn = 0;
    s_awvalid[0] = 1; s_wvalid[0] = 1; s_arvalid[1] = 1; s_bready[0] = 1; s_rready[1] = 1;
    s_awaddr[0] = 8'hFF; s_wdata[0] = 32'hFFFF_FFFF; s_wstrb[0] = 4'hF; s_araddr[1] = 8'hAA;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    ctl = {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
           s_awready[0], s_awready[1], s_wready[0], s_wready[1], s_bvalid[0], s_bvalid[1],
           s_arready[0], s_arready[1], s_rvalid[0], s_rvalid[1], 1'b0};
    vectors++;
    if (ctl !== 16'h0) begin
      miscompares++; $display("FAIL reset_ctl: got %h expected 0000", ctl);
    end
    dat = {m_awaddr, m_wdata[15:0], m_wstrb, m_araddr, s_rdata[0][7:0], s_rdata[1][7:0],
           s_bresp[0], s_bresp[1], s_rresp[0], s_rresp[1], m_awprot, m_arprot};
    vectors++;
    if (dat !== 64'h0) begin
      miscompares++; $display("FAIL reset_data: got %h expected 0", dat);
    end
    s_awvalid[0] = 0; s_wvalid[0] = 0; s_arvalid[1] = 0; s_bready[0] = 0; s_rready[1] = 0;
    @(posedge aclk); #1;
    aresetn = 1;
    cyc(2);
  endtask

  task automatic test_single_write;
    bit ok; logic [1:0] resp; int lat, t, act_w1, act_r1, awc;
    act_w1 = wr_act[1]; act_r1 = rd_act[1]; awc = aw_cnt;
    b_delay = 2; bresp_val = AXI_OKAY;
    mwrite(0, 8'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, ok, resp, lat, t);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL single_done: got ok=%0d expected 1", ok); end
    vectors++;
    if (last_awaddr !== 8'h10) begin miscompares++; $display("FAIL single_awaddr: got %h expected 10", last_awaddr); end
    vectors++;
    if (last_wdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL single_wdata: got %h expected deadbeef", last_wdata); end
    vectors++;
    if (last_wstrb !== 4'hF) begin miscompares++; $display("FAIL single_wstrb: got %h expected f", last_wstrb); end
    vectors++;
    if (resp !== AXI_OKAY) begin miscompares++; $display("FAIL single_bresp: got %b expected 00", resp); end
    vectors++;
    if (lat !== 1) begin miscompares++; $display("FAIL single_aw_latency: got %0d expected 1", lat); end
    vectors++;
    if (aw_cnt - awc !== 1) begin miscompares++; $display("FAIL single_aw_count: got %0d expected 1", aw_cnt - awc); end
    vectors++;
    if (wr_act[1] != act_w1 || rd_act[1] != act_r1) begin
      miscompares++; $display("FAIL single_s1_quiet: got %0d/%0d active cycles expected 0/0",
                               wr_act[1] - act_w1, rd_act[1] - act_r1);
    end
  endtask

  task automatic test_rr_arbitration;
    bit ok0, ok1; logic [1:0] r0, r1; int l0, l1, t0, t1;
    bit exp_s0_first;
    // Solo s1 transaction leaves the round-robin pointer on port 0.
    mwrite(1, 8'h00, 32'h0000_0001, 4'hF, 0, 0, ok1, r1, l1, t1);
    fork
      mwrite(0, 8'h04, 32'h0404_0404, 4'hF, 0, 0, ok0, r0, l0, t0);
      mwrite(1, 8'h08, 32'h0808_0808, 4'hF, 0, 0, ok1, r1, l1, t1);
    join
    vectors++;
    if (!(ok0 && ok1 && t0 < t1)) begin
      miscompares++; $display("FAIL rr_round1_order: got ok=%0d%0d s0_end=%0d s1_end=%0d expected s0 first", ok0, ok1, t0, t1);
    end
    vectors++;
    if (last_awaddr !== 8'h08) begin miscompares++; $display("FAIL rr_round1_last: got %h expected 08", last_awaddr); end
    // Solo s0 transaction moves the round-robin pointer to port 1.
    mwrite(0, 8'h0C, 32'h0C0C_0C0C, 4'hF, 0, 0, ok0, r0, l0, t0);
`ifdef CSR_ARB_FIXED_PRIO_EN
    exp_s0_first = 1;
`else
    exp_s0_first = 0;
`endif
    fork
      mwrite(0, 8'h04, 32'h4444_4444, 4'hF, 0, 0, ok0, r0, l0, t0);
      mwrite(1, 8'h08, 32'h8888_8888, 4'hF, 0, 0, ok1, r1, l1, t1);
    join
    vectors++;
    if (!(ok0 && ok1) || (t0 < t1) != exp_s0_first) begin
      miscompares++; $display("FAIL rr_round2_order: got ok=%0d%0d s0_end=%0d s1_end=%0d expected s0_first=%0d", ok0, ok1, t0, t1, exp_s0_first);
    end
    vectors++;
    if (last_awaddr !== (exp_s0_first ? 8'h08 : 8'h04)) begin
      miscompares++; $display("FAIL rr_round2_last: got %h expected %h", last_awaddr, exp_s0_first ? 8'h08 : 8'h04);
    end
    vectors++;
    if (last_wdata !== (exp_s0_first ? 32'h8888_8888 : 32'h4444_4444)) begin
      miscompares++; $display("FAIL rr_round2_wdata: got %h", last_wdata);
    end
  endtask

  task automatic test_concurrent_rw;
    bit okr, okw; logic [DW-1:0] rd; logic [1:0] rw; int lw, tr, tw, act_w1, act_r0;
    rdata_val = 32'hCAFE_F00D; act_w1 = wr_act[1]; act_r0 = rd_act[0];
    fork
      mread(1, 8'h20, okr, rd, tr);
      mwrite(0, 8'h24, 32'h2424_2424, 4'hF, 0, 0, okw, rw, lw, tw);
    join
    vectors++;
    if (!(okr && okw)) begin miscompares++; $display("FAIL conc_done: got rd=%0d wr=%0d expected 1/1", okr, okw); end
    vectors++;
    if (rd !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL conc_rdata: got %h expected cafef00d", rd); end
    vectors++;
    if (last_araddr !== 8'h20 || last_awaddr !== 8'h24) begin
      miscompares++; $display("FAIL conc_addr: got ar=%h aw=%h expected 20/24", last_araddr, last_awaddr);
    end
    vectors++;
    if (wr_act[1] != act_w1 || rd_act[0] != act_r0) begin
      miscompares++; $display("FAIL conc_no_cross: got s1wr=%0d s0rd=%0d expected 0/0", wr_act[1] - act_w1, rd_act[0] - act_r0);
    end
    vectors++;
    if (tr > tw) begin miscompares++; $display("FAIL conc_overlap: got rd_end=%0d wr_end=%0d expected rd_end<=wr_end", tr, tw); end
  endtask

  task automatic test_w_first_backpressure;
    bit ok; logic [1:0] resp; int lat, t, bc;
    bc = b_cnt; b_delay = 1; bresp_val = AXI_SLVERR;
    mwrite(0, 8'h30, 32'h1234_5678, 4'h5, 3, 4, ok, resp, lat, t);
    @(negedge aclk);
    vectors++;
    if (dut.wr_state_q !== WR_IDLE) begin miscompares++; $display("FAIL bp_idle: got state %0d expected %0d", dut.wr_state_q, WR_IDLE); end
    vectors++;
    if (!ok || resp !== AXI_SLVERR) begin miscompares++; $display("FAIL bp_bresp: got ok=%0d resp=%b expected 1/10", ok, resp); end
    vectors++;
    if (b_cnt - bc !== 1) begin miscompares++; $display("FAIL bp_b_count: got %0d expected 1", b_cnt - bc); end
    vectors++;
    if (last_wdata !== 32'h1234_5678 || last_wstrb !== 4'h5) begin
      miscompares++; $display("FAIL bp_wdata: got %h/%h expected 12345678/5", last_wdata, last_wstrb);
    end
    vectors++;
    if (lat !== 1) begin miscompares++; $display("FAIL bp_aw_latency: got %0d expected 1", lat); end
    bresp_val = AXI_OKAY; b_delay = 2;
    @(posedge aclk); #1;
  endtask

  task automatic test_reset_in_resp;
    bit okx, ok; logic [1:0] rx, resp; int lx, tx, lat, t, n;
    logic [7:0] outs;
    fork
      mwrite(0, 8'h40, 32'h4040_4040, 4'hF, 0, 100, okx, rx, lx, tx);
      begin
        n = 0;
        while (n < 30) begin
          @(negedge aclk);
          if (s_bvalid[0]) break;
          n++;
        end
        vectors++;
        if (n >= 30) begin miscompares++; $display("FAIL rst_reach_resp: got timeout expected s0_bvalid"); end
        @(posedge aclk); #1;
        aresetn = 0;
        #1;
        outs = {s_bvalid[0], s_bvalid[1], m_bready, m_awvalid, m_wvalid, m_arvalid, s_bresp[0]};
        vectors++;
        if (outs !== 8'h0) begin miscompares++; $display("FAIL rst_outputs: got %h expected 00", outs); end
        cyc(2);
        aresetn = 1;
      end
    join
    mwrite(1, 8'h44, 32'hA5A5_A5A5, 4'hF, 0, 0, ok, resp, lat, t);
    vectors++;
    if (!ok || resp !== AXI_OKAY) begin miscompares++; $display("FAIL rst_s1_write: got ok=%0d resp=%b expected 1/00", ok, resp); end
    vectors++;
    if (last_awaddr !== 8'h44 || last_wdata !== 32'hA5A5_A5A5) begin
      miscompares++; $display("FAIL rst_s1_data: got %h/%h expected 44/a5a5a5a5", last_awaddr, last_wdata);
    end
    vectors++;
    if (lat !== 1) begin miscompares++; $display("FAIL rst_s1_latency: got %0d expected 1", lat); end
  endtask

  initial begin
    aresetn = 0;
    m_awready = 1; m_wready = 1; m_arready = 1;
    for (int p = 0; p < 2; p++) begin
      s_awvalid[p] = 0; s_awaddr[p] = 0; s_awprot[p] = 0;
      s_wvalid[p] = 0; s_wdata[p] = 0; s_wstrb[p] = 0; s_bready[p] = 0;
      s_arvalid[p] = 0; s_araddr[p] = 0; s_arprot[p] = 0; s_rready[p] = 0;
    end
    test_reset();
    test_single_write();
    test_rr_arbitration();
    test_concurrent_rw();
    test_w_first_backpressure();
    test_reset_in_resp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
